spin_score_engine: RTL



---
 rtl/spin_score_engine.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/spin_score_engine.sv
// Spin-aware score engine: classifies a lock event, scales by level with a serial adder, commits to score/combo/B2B.
// Optional perfect-clear bonus and award kind 13 are built when PERFECT_CLEAR_EN is defined.
module spin_score_engine #(
  parameter int SCORE_W   = 24,
  parameter int POINTS_W  = 18,
  parameter int COMBO_MAX = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lock_valid,
  output logic                lock_ready,
  input  logic                is_t_spin,
  input  logic                is_t_spin_mini,
  input  logic                is_other_spin,
  input  logic [2:0]          lines_cleared,
  input  logic [4:0]          level,
`ifdef PERFECT_CLEAR_EN
  input  logic                perfect_clear,
`endif
  output logic                award_valid,
  output logic [POINTS_W-1:0] award_points,
  output logic [3:0]          award_kind,
  output logic [SCORE_W-1:0]  score,
  output logic [4:0]          combo,
  output logic                b2b_active
);
  typedef enum logic [1:0] {IDLE, CLASSIFY, MULTIPLY, COMMIT} state_e;

  state_e state_q, state_d;

  logic                ts_q, mini_q, oth_q, pc_q;
  logic [2:0]          lines_q;
  logic [4:0]          lvl_q, cnt_q;
  logic [POINTS_W-1:0] sum_q, acc_q, ap_q;
  logic [SCORE_W-1:0]  score_q;
  logic [4:0]          combo_q;
  logic                live_q, b2b_q, av_q;
  logic [3:0]          ak_q;

  logic                accept;
  logic                use_t, use_m, spin, difficult;
  logic [1:0]          tl;
  logic [POINTS_W-1:0] base, base_b2b, pc_bonus, sum_d;
  logic [4:0]          combo_d;
  logic                live_d, b2b_d;
  logic [3:0]          kind_d;
  logic [SCORE_W:0]    score_sum;

  assign lock_ready = (state_q == IDLE);
  assign accept     = lock_valid & lock_ready;

  // Classification works entirely from the latched event and the pre-commit combo/B2B state.
  always_comb begin
    tl        = (lines_q > 3'd3) ? 2'd3 : lines_q[1:0];
    spin      = ts_q | mini_q | oth_q;
    use_t     = ts_q | (mini_q & (lines_q >= 3'd3));
    use_m     = ~use_t & (mini_q | (oth_q & (lines_q <= 3'd2)));
    difficult = (lines_q == 3'd4) | (spin & (lines_q != 3'd0));

    base = '0;
    if (use_t) begin
      case (tl)
        2'd0:    base = POINTS_W'(400);
        2'd1:    base = POINTS_W'(800);
        2'd2:    base = POINTS_W'(1200);
        default: base = POINTS_W'(1600);
      endcase
    end else if (use_m) begin
      case (lines_q[1:0])
        2'd0:    base = POINTS_W'(100);
        2'd1:    base = POINTS_W'(200);
        default: base = POINTS_W'(400);
      endcase
    end else begin
      case (lines_q)
        3'd0:    base = '0;
        3'd1:    base = POINTS_W'(100);
        3'd2:    base = POINTS_W'(300);
        3'd3:    base = POINTS_W'(500);
        default: base = POINTS_W'(800);
      endcase
    end

    base_b2b = (difficult & b2b_q) ? base + (base >> 1) : base;

    combo_d = '0;
    live_d  = 1'b0;
    if (lines_q != 3'd0) begin
      live_d  = 1'b1;
      if (live_q)
        combo_d = (combo_q == 5'(COMBO_MAX)) ? combo_q : combo_q + 5'd1;
    end

    b2b_d = b2b_q;
    if (difficult)                     b2b_d = 1'b1;
    else if (!spin && lines_q != 3'd0) b2b_d = 1'b0;

    pc_bonus = '0;
`ifdef PERFECT_CLEAR_EN
    if (pc_q && lines_q != 3'd0) begin
      case (lines_q)
        3'd1:    pc_bonus = POINTS_W'(800);
        3'd2:    pc_bonus = POINTS_W'(1200);
        3'd3:    pc_bonus = POINTS_W'(1800);
        default: pc_bonus = POINTS_W'(2000);
      endcase
    end
`endif

    sum_d = base_b2b + POINTS_W'(combo_d) * POINTS_W'(50) + pc_bonus;

    // Spin classes win over the perfect-clear kind; mini 3+ reports as a T-spin.
    if (use_t)                           kind_d = 4'd5 + {2'b00, tl};
    else if (mini_q)                     kind_d = 4'd9 + {2'b00, lines_q[1:0]};
    else if (oth_q)                      kind_d = 4'd12;
    else if (pc_q && lines_q != 3'd0)    kind_d = 4'd13;
    else                                 kind_d = {1'b0, lines_q};

    score_sum = {1'b0, score_q} + (SCORE_W+1)'(acc_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = CLASSIFY;
      CLASSIFY: state_d = MULTIPLY;
      MULTIPLY: if (cnt_q == 5'd1) state_d = COMMIT;
      COMMIT:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= 1'b0;
      mini_q  <= 1'b0;
      oth_q   <= 1'b0;
      pc_q    <= 1'b0;
      lines_q <= '0;
      lvl_q   <= 5'd1;
      cnt_q   <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      ap_q    <= '0;
      ak_q    <= '0;
      av_q    <= 1'b0;
      score_q <= '0;
      combo_q <= '0;
      live_q  <= 1'b0;
      b2b_q   <= 1'b0;
    end else begin
      av_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          ts_q    <= is_t_spin;
          mini_q  <= is_t_spin_mini;
          oth_q   <= is_other_spin;
`ifdef PERFECT_CLEAR_EN
          pc_q    <= perfect_clear;
`else
          pc_q    <= 1'b0;
`endif
          lines_q <= (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
          lvl_q   <= (level == 5'd0) ? 5'd1 : level;
        end
        CLASSIFY: begin
          sum_q <= sum_d;
          acc_q <= '0;
          cnt_q <= lvl_q;
        end
        MULTIPLY: begin
          acc_q <= acc_q + sum_q;
          cnt_q <= cnt_q - 5'd1;
        end
        COMMIT: begin
          score_q <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
          ap_q    <= acc_q;
          ak_q    <= kind_d;
          av_q    <= 1'b1;
          combo_q <= combo_d;
          live_q  <= live_d;
          b2b_q   <= b2b_d;
        end
        default: ;
      endcase
    end
  end

  assign award_valid  = av_q;
  assign award_points = ap_q;
  assign award_kind   = ak_q;
  assign score        = score_q;
  assign combo        = combo_q;
  assign b2b_active   = b2b_q;
endmodule
